instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/cpu_pkg.sv | 14 +
 rtl/fetch_timer.sv | 26 ++
 rtl/instr_fetch.sv | 123 ++++++++++++
 tb/tb_instr_fetch.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width and the instruction-fetch state encoding.
package cpu_pkg;

    localparam int unsigned DATA_W = 32;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_HOLD  = 3'd2,
        S_DRAIN = 3'd3,
        S_ERR   = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/fetch_timer.sv
// Wait-cycle counter for the fetch stage; expired marks the TIMEOUT-th cycle without ack.
module fetch_timer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 8'd1;
        end
    end

    // Fires during the cycle that would bring the count to TIMEOUT, so the
    // FSM leaves WAIT/DRAIN after exactly TIMEOUT cycles without ack.
    assign expired = en && (count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: one outstanding imem read, an instruction register
// held until consumed, flush/drain handling and a sticky timeout error.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W  = cpu_pkg::DATA_W,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] pc_in,
    input  logic              fetch_start,
    input  logic              flush,
    output logic              imem_req,
    output logic [DATA_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] ir_out,
    output logic [DATA_W-1:0] npc_out,
    output logic              ir_valid,
    input  logic              ir_consume,
    output logic              busy,
    output logic              fetch_err
);

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [DATA_W-1:0] addr;
    logic              load_pc;
    logic              load_ir;
    logic              timer_clr;
    logic              timer_en;
    logic              expired;

    fetch_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (timer_clr),
        .en     (timer_en),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            addr    <= '0;
            ir_out  <= '0;
            npc_out <= '0;
        end else begin
            state <= state_next;
            if (load_pc) begin
                addr <= pc_in;
            end
            if (load_ir) begin
                ir_out  <= imem_rdata;
                npc_out <= addr + DATA_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        load_pc    = 1'b0;
        load_ir    = 1'b0;
        case (state)
            S_IDLE: begin
                if (fetch_start) begin
                    load_pc    = 1'b1;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                // An ack in the flush cycle completes the handshake, so no drain is needed.
                if (imem_ack) begin
                    load_ir    = !flush;
                    state_next = flush ? S_IDLE : S_HOLD;
                end else if (flush) begin
                    state_next = S_DRAIN;
                end else if (expired) begin
                    state_next = S_ERR;
                end
            end
            S_HOLD: begin
                if (flush) begin
                    state_next = S_IDLE;
                end else if (ir_consume) begin
                    if (fetch_start) begin
                        load_pc    = 1'b1;
                        state_next = S_WAIT;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            S_DRAIN: begin
                if (imem_ack) begin
                    state_next = S_IDLE;
                end else if (expired) begin
                    state_next = S_ERR;
                end
            end
            S_ERR: begin
                state_next = S_ERR;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign timer_clr = (state_next != state) &&
                       ((state_next == S_WAIT) || (state_next == S_DRAIN));
    assign timer_en  = ((state == S_WAIT) || (state == S_DRAIN)) && !imem_ack;

    assign imem_req  = (state == S_WAIT) || (state == S_DRAIN);
    assign imem_addr = addr;
    assign ir_valid  = (state == S_HOLD);
    assign busy      = (state != S_IDLE);
    assign fetch_err = (state == S_ERR);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic        fetch_start;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] ir_out;
    logic [31:0] npc_out;
    logic        ir_valid;
    logic        ir_consume;
    logic        busy;
    logic        fetch_err;

    int checks = 0;
    int fails  = 0;

    instr_fetch #(
        .DATA_W (32),
        .TIMEOUT(15)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_in      (pc_in),
        .fetch_start(fetch_start),
        .flush      (flush),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .ir_out     (ir_out),
        .npc_out    (npc_out),
        .ir_valid   (ir_valid),
        .ir_consume (ir_consume),
        .busy       (busy),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        fetch_start = 1'b0;
        flush       = 1'b0;
        imem_ack    = 1'b0;
        ir_consume  = 1'b0;
        imem_rdata  = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pc_in = '0;
        idle_inputs();
        step();
        step();
        rst = 1'b0;
        checks++; if (imem_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %0b exp 0", imem_req); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b exp 0", busy); end
        checks++; if (ir_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b exp 0", ir_valid); end
        checks++; if (fetch_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %0b exp 0", fetch_err); end
        checks++; if ({ir_out, npc_out, imem_addr} !== 96'h0) begin fails++; $display("FAIL reset_regs: got %h %h %h exp 0", ir_out, npc_out, imem_addr); end
    endtask

    task automatic test_basic_fetch();
        pc_in = 32'h10;
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        checks++; if (imem_req !== 1'b1) begin fails++; $display("FAIL basic_req: got %0b exp 1", imem_req); end
        checks++; if (imem_addr !== 32'h10) begin fails++; $display("FAIL basic_addr: got %h exp 00000010", imem_addr); end
        checks++; if (ir_valid !== 1'b0) begin fails++; $display("FAIL basic_valid_early: got %0b exp 0", ir_valid); end
        imem_ack = 1'b1;
        imem_rdata = 32'hA5A5A5A5;
        step();
        idle_inputs();
        checks++; if (ir_valid !== 1'b1) begin fails++; $display("FAIL basic_valid: got %0b exp 1", ir_valid); end
        checks++; if (ir_out !== 32'hA5A5A5A5) begin fails++; $display("FAIL basic_ir: got %h exp a5a5a5a5", ir_out); end
        checks++; if (npc_out !== 32'h11) begin fails++; $display("FAIL basic_npc: got %h exp 00000011", npc_out); end
        checks++; if (imem_req !== 1'b0) begin fails++; $display("FAIL basic_req_hold: got %0b exp 0", imem_req); end
        // fetch_start without consume is ignored in HOLD
        pc_in = 32'h99;
        fetch_start = 1'b1;
        step();
        step();
        fetch_start = 1'b0;
        checks++; if ({ir_valid, imem_req} !== 2'b10) begin fails++; $display("FAIL hold_stable_flags: got %b exp 10", {ir_valid, imem_req}); end
        checks++; if (ir_out !== 32'hA5A5A5A5 || npc_out !== 32'h11) begin fails++; $display("FAIL hold_stable_data: got %h %h exp a5a5a5a5 00000011", ir_out, npc_out); end
    endtask

    task automatic test_back_to_back();
        pc_in = 32'h11;
        ir_consume = 1'b1;
        fetch_start = 1'b1;
        step();
        idle_inputs();
        checks++; if (imem_req !== 1'b1) begin fails++; $display("FAIL b2b_req: got %0b exp 1", imem_req); end
        checks++; if (imem_addr !== 32'h11) begin fails++; $display("FAIL b2b_addr: got %h exp 00000011", imem_addr); end
        checks++; if (ir_valid !== 1'b0) begin fails++; $display("FAIL b2b_valid: got %0b exp 0", ir_valid); end
        imem_ack = 1'b1;
        imem_rdata = 32'h12345678;
        step();
        idle_inputs();
        checks++; if (ir_out !== 32'h12345678 || npc_out !== 32'h12) begin fails++; $display("FAIL b2b_data: got %h %h exp 12345678 00000012", ir_out, npc_out); end
        ir_consume = 1'b1;
        step();
        idle_inputs();
        checks++; if ({ir_valid, busy} !== 2'b00) begin fails++; $display("FAIL consume_idle: got %b exp 00", {ir_valid, busy}); end
    endtask

    task automatic test_flush_wait();
        pc_in = 32'h20;
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++; if ({imem_req, busy, ir_valid} !== 3'b110) begin fails++; $display("FAIL drain_state: got %b exp 110", {imem_req, busy, ir_valid}); end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if ({imem_req, ir_valid} !== 2'b10) begin fails++; $display("FAIL drain_wait%0d: got %b exp 10", i, {imem_req, ir_valid}); end
        end
        imem_ack = 1'b1;
        imem_rdata = 32'hDEADBEEF;
        step();
        idle_inputs();
        checks++; if ({busy, ir_valid, imem_req} !== 3'b000) begin fails++; $display("FAIL drain_done: got %b exp 000", {busy, ir_valid, imem_req}); end
        checks++; if (ir_out !== 32'h12345678) begin fails++; $display("FAIL drain_ir_kept: got %h exp 12345678", ir_out); end
    endtask

    task automatic test_flush_with_ack();
        pc_in = 32'h30;
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        flush = 1'b1;
        imem_ack = 1'b1;
        imem_rdata = 32'h0BADF00D;
        step();
        idle_inputs();
        checks++; if ({busy, ir_valid, imem_req} !== 3'b000) begin fails++; $display("FAIL flush_ack: got %b exp 000", {busy, ir_valid, imem_req}); end
    endtask

    task automatic test_flush_hold();
        pc_in = 32'h34;
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = 32'h11112222;
        step();
        idle_inputs();
        flush = 1'b1;
        ir_consume = 1'b1;
        fetch_start = 1'b1;
        pc_in = 32'h77;
        step();
        idle_inputs();
        checks++; if ({busy, ir_valid, imem_req} !== 3'b000) begin fails++; $display("FAIL flush_hold: got %b exp 000", {busy, ir_valid, imem_req}); end
    endtask

    task automatic test_wrap();
        pc_in = 32'hFFFFFFFF;
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = 32'h00C0FFEE;
        step();
        idle_inputs();
        checks++; if (npc_out !== 32'h0) begin fails++; $display("FAIL wrap_npc: got %h exp 00000000", npc_out); end
        checks++; if (ir_out !== 32'h00C0FFEE) begin fails++; $display("FAIL wrap_ir: got %h exp 00c0ffee", ir_out); end
        ir_consume = 1'b1;
        step();
        idle_inputs();
    endtask

    task automatic test_late_ack();
        // ack on the 15th wait cycle still completes the fetch
        pc_in = 32'h60;
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        for (int i = 0; i < 14; i++) step();
        imem_ack = 1'b1;
        imem_rdata = 32'h5A5A0F0F;
        step();
        idle_inputs();
        checks++; if ({ir_valid, fetch_err} !== 2'b10) begin fails++; $display("FAIL late_ack: got %b exp 10", {ir_valid, fetch_err}); end
        checks++; if (ir_out !== 32'h5A5A0F0F) begin fails++; $display("FAIL late_ack_ir: got %h exp 5a5a0f0f", ir_out); end
        ir_consume = 1'b1;
        step();
        idle_inputs();
    endtask

    task automatic test_timeout();
        pc_in = 32'h40;
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        for (int i = 0; i < 14; i++) begin
            step();
            checks++; if ({imem_req, fetch_err} !== 2'b10) begin fails++; $display("FAIL timeout_wait%0d: got %b exp 10", i, {imem_req, fetch_err}); end
        end
        step();
        checks++; if ({fetch_err, imem_req, ir_valid} !== 3'b100) begin fails++; $display("FAIL timeout_err: got %b exp 100", {fetch_err, imem_req, ir_valid}); end
        pc_in = 32'h44;
        fetch_start = 1'b1;
        step();
        step();
        fetch_start = 1'b0;
        checks++; if ({fetch_err, imem_req, busy} !== 3'b101) begin fails++; $display("FAIL err_absorb: got %b exp 101", {fetch_err, imem_req, busy}); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if ({fetch_err, busy} !== 2'b00) begin fails++; $display("FAIL err_reset: got %b exp 00", {fetch_err, busy}); end
    endtask

    task automatic test_reset_in_wait();
        pc_in = 32'h80;
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if ({imem_req, busy, ir_valid, fetch_err} !== 4'b0000) begin fails++; $display("FAIL rst_wait_flags: got %b exp 0000", {imem_req, busy, ir_valid, fetch_err}); end
        checks++; if ({ir_out, npc_out, imem_addr} !== 96'h0) begin fails++; $display("FAIL rst_wait_regs: got %h %h %h exp 0", ir_out, npc_out, imem_addr); end
        pc_in = 32'h50;
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        checks++; if (imem_addr !== 32'h50) begin fails++; $display("FAIL rst_refetch_addr: got %h exp 00000050", imem_addr); end
        imem_ack = 1'b1;
        imem_rdata = 32'hCAFEF00D;
        step();
        idle_inputs();
        checks++; if (ir_valid !== 1'b1 || ir_out !== 32'hCAFEF00D || npc_out !== 32'h51) begin fails++; $display("FAIL rst_refetch: got %0b %h %h exp 1 cafef00d 00000051", ir_valid, ir_out, npc_out); end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_back_to_back();
        test_flush_wait();
        test_flush_with_ack();
        test_flush_hold();
        test_wrap();
        test_late_ack();
        test_timeout();
        test_reset_in_wait();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
